// File: rtl/mmu_systolic_array_if.sv
// rtl/mmu_systolic_array_if.sv - feeder to MMU operand/result bundle
//
// Purpose: carries the skewed operand streams and clear from the feeder into
//          the 2x2 systolic array, and the four accumulators plus the
//          result-valid flag back out.
// Signals:
//   clear                  flush of accumulators, pipeline and step counter
//   a_data0, a_data1       row operands entering from the left (DATA_W)
//   b_data0, b_data1       column operands entering from the top (DATA_W)
//   c00, c01, c10, c11     per-PE accumulators (ACC_W, two's complement)
//   valid                  all four results final for a standard schedule
// Modports: master = feeder, slave = array.
interface mmu_systolic_array_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
);
  logic              clear;
  logic [DATA_W-1:0] a_data0;
  logic [DATA_W-1:0] a_data1;
  logic [DATA_W-1:0] b_data0;
  logic [DATA_W-1:0] b_data1;
  logic [ACC_W-1:0]  c00;
  logic [ACC_W-1:0]  c01;
  logic [ACC_W-1:0]  c10;
  logic [ACC_W-1:0]  c11;
  logic              valid;

  modport master (
    output clear, a_data0, a_data1, b_data0, b_data1,
    input  c00, c01, c10, c11, valid
  );

  modport slave (
    input  clear, a_data0, a_data1, b_data0, b_data1,
    output c00, c01, c10, c11, valid
  );
endinterface

// File: rtl/mmu_systolic_array.sv
// rtl/mmu_systolic_array.sv - 2x2 output-stationary systolic array
//
// Purpose: computes C = A x B for 2x2 signed operands fed on a diagonal skew.
//          Each PE multiplies its left (a) and top (b) operands, adds the
//          product into its own accumulator and forwards the operands right
//          and down one cycle later.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   mmu    slave side of mmu_systolic_array_if (operands, clear, results)
module mmu_systolic_array #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmu_systolic_array_if.slave  mmu
);

  // Signed multiply-accumulate with wrap. Sign-extending both operands to
  // ACC_W before multiplying gives the low ACC_W bits of the full product.
  function automatic logic [ACC_W-1:0] mac(
    input logic [ACC_W-1:0]  acc,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [ACC_W-1:0] ax;
    logic signed [ACC_W-1:0] bx;
    ax = ACC_W'($signed(a));
    bx = ACC_W'($signed(b));
    return acc + ACC_W'(ax * bx);
  endfunction

  logic [ACC_W-1:0]  acc00, acc01, acc10, acc11;
  // Forwarding registers. Only operands that reach a neighbouring PE are
  // kept; the a_out of the right column and b_out of the bottom row leave
  // the array with no consumer.
  logic [DATA_W-1:0] a_out00, a_out10;
  logic [DATA_W-1:0] b_out00, b_out01;
  logic [2:0]        step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc00   <= '0;
      acc01   <= '0;
      acc10   <= '0;
      acc11   <= '0;
      a_out00 <= '0;
      a_out10 <= '0;
      b_out00 <= '0;
      b_out01 <= '0;
      step    <= '0;
    end else if (mmu.clear) begin
      acc00   <= '0;
      acc01   <= '0;
      acc10   <= '0;
      acc11   <= '0;
      a_out00 <= '0;
      a_out10 <= '0;
      b_out00 <= '0;
      b_out01 <= '0;
      step    <= '0;
    end else begin
      acc00   <= mac(acc00, mmu.a_data0, mmu.b_data0);
      acc01   <= mac(acc01, a_out00,     mmu.b_data1);
      acc10   <= mac(acc10, mmu.a_data1, b_out00);
      acc11   <= mac(acc11, a_out10,     b_out01);
      a_out00 <= mmu.a_data0;
      a_out10 <= mmu.a_data1;
      b_out00 <= mmu.b_data0;
      b_out01 <= mmu.b_data1;
      // Saturate so valid stays high while results are held.
      if (step != 3'd7) begin
        step <= step + 3'd1;
      end
    end
  end

  assign mmu.c00   = acc00;
  assign mmu.c01   = acc01;
  assign mmu.c10   = acc10;
  assign mmu.c11   = acc11;
  // step >= 4 is exactly its MSB.
  assign mmu.valid = step[2];

endmodule

// File: tb/tb_mmu_systolic_array.sv
// tb/tb_mmu_systolic_array.sv - directed self-checking bench for mmu_systolic_array
module tb_mmu_systolic_array;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mmu_systolic_array_if #(.DATA_W(8), .ACC_W(16)) bus ();

  mmu_systolic_array #(.DATA_W(8), .ACC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mmu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e00, input logic [15:0] e01,
                           input logic [15:0] e10, input logic [15:0] e11, input logic ev);
    check({tag, ".c00"},   32'(bus.c00),   32'(e00));
    check({tag, ".c01"},   32'(bus.c01),   32'(e01));
    check({tag, ".c10"},   32'(bus.c10),   32'(e10));
    check({tag, ".c11"},   32'(bus.c11),   32'(e11));
    check({tag, ".valid"}, 32'(bus.valid), 32'(ev));
  endtask

  // Drive one cycle of operands, then land 1 time unit after the edge.
  task automatic cyc(input int a0, input int a1, input int b0, input int b1);
    bus.a_data0 = 8'(a0);
    bus.a_data1 = 8'(a1);
    bus.b_data0 = 8'(b0);
    bus.b_data1 = 8'(b1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cyc(0, 0, 0, 0);
    bus.clear = 1'b0;
  endtask

  // Standard feeder schedule t0..t3 for A = [w0 w1; w2 w3], B = [i0 i1; i2 i3].
  task automatic run_batch(input int w0, input int w1, input int w2, input int w3,
                           input int i0, input int i1, input int i2, input int i3);
    cyc(w0, 0,  i0, 0);
    cyc(w1, w2, i2, i1);
    cyc(0,  w3, 0,  i3);
    cyc(0,  0,  0,  0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.clear   = 1'b0;
    bus.a_data0 = 8'd9;
    bus.a_data1 = 8'd7;
    bus.b_data0 = 8'd3;
    bus.b_data1 = 8'd5;

    // Reset with nonzero operands and a running clock.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b1;
    bus.clear = 1'b1;
    cyc(9, 7, 3, 5);
    cyc(9, 7, 3, 5);
    bus.clear = 1'b0;
    check_all("clear_hold", 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);

    // Basic batch with per-step latency checks.
    cyc(1, 0, 5, 0);
    check("basic_t0.c00", 32'(bus.c00), 32'd5);
    check("basic_t0.valid", 32'(bus.valid), 32'd0);
    cyc(2, 3, 7, 6);
    check("basic_t1.c00", 32'(bus.c00), 32'd19);
    check("basic_t1.c01", 32'(bus.c01), 32'd6);
    check("basic_t1.c10", 32'(bus.c10), 32'd15);
    check("basic_t1.valid", 32'(bus.valid), 32'd0);
    cyc(0, 4, 0, 8);
    check_all("basic_t2", 16'd19, 16'd22, 16'd43, 16'd18, 1'b0);
    cyc(0, 0, 0, 0);
    check_all("basic_t3", 16'd19, 16'd22, 16'd43, 16'd50, 1'b1);
    repeat (4) cyc(0, 0, 0, 0);
    check_all("basic_t7", 16'd19, 16'd22, 16'd43, 16'd50, 1'b1);

    // Signed operands.
    do_clear();
    run_batch(-1, 2, 3, -4, 5, -6, 7, 8);
    check_all("signed", 16'd9, 16'd22, 16'hFFF3, 16'hFFCE, 1'b1);

    // Wrap and no-wrap extremes.
    do_clear();
    run_batch(-128, -128, -128, -128, -128, -128, -128, -128);
    check_all("wrap_neg", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1);
    do_clear();
    run_batch(127, 127, 127, 127, 127, 127, 127, 127);
    check_all("max_pos", 16'h7E02, 16'h7E02, 16'h7E02, 16'h7E02, 1'b1);

    // Accumulate across batches, then clear mid-batch.
    do_clear();
    run_batch(1, 2, 3, 4, 5, 6, 7, 8);
    run_batch(1, 2, 3, 4, 5, 6, 7, 8);
    check_all("accum2", 16'd38, 16'd44, 16'd86, 16'd100, 1'b1);
    cyc(1, 0, 5, 0);
    bus.clear = 1'b1;
    cyc(2, 3, 7, 6);
    bus.clear = 1'b0;
    check_all("mid_clear", 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    run_batch(1, 2, 3, 4, 5, 6, 7, 8);
    check_all("after_clear", 16'd19, 16'd22, 16'd43, 16'd50, 1'b1);

    // Asynchronous reset between edges at t2.
    do_clear();
    cyc(1, 0, 5, 0);
    cyc(2, 3, 7, 6);
    cyc(0, 4, 0, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    bus.a_data0 = 8'd0;
    bus.a_data1 = 8'd0;
    bus.b_data0 = 8'd0;
    bus.b_data1 = 8'd0;
    #2;
    rst_n = 1'b1;
    run_batch(1, 2, 3, 4, 5, 6, 7, 8);
    check_all("after_rst", 16'd19, 16'd22, 16'd43, 16'd50, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
